fnd_src_scheduler: RTL
======================

Name: fnd_src_scheduler

Overview:
Selection controller for the 7-segment display source mux. It generates the one-hot source select that picks one of NUM_SRC 8-bit register sources: local slave regs 0-5 and master regs 0-5. Selection comes either from the board switches (manual) or from an automatic round-robin with a programmable dwell time, plus pause and step controls. The block sits between the switch/button inputs and the source mux, and drives the mux select in place of the raw switches.

Parameters:
NUM_SRC, 12, number of selectable sources (index width IDX_W = 4, fixed)
DWELL_CYCLES, 100_000_000, clk cycles each source is shown in auto mode (1 s at 100 MHz); legal range >= 2

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge)
sw  input  15  board switches; sw[14] = auto enable, sw[NUM_SRC-1:0] = manual one-hot source select
pause  input  1  level; freezes auto rotation while high
step  input  1  single-cycle pulse, already debounced/edge-detected; advances auto rotation by one source
src_data  input  NUM_SRC*8  flattened source bytes, source k at [8k+7:8k]; used only with CHG_JUMP_EN
sel_onehot  output  NUM_SRC  one-hot select to the source mux; all-zero = blank (mux outputs 0)
sel_idx  output  4  binary index of the selected source
mode  output  2  0 = MANUAL, 1 = AUTO, 2 = HOLD, 3 unused
wrap  output  1  one-cycle pulse when auto rotation wraps from NUM_SRC-1 to 0

Behaviour:
- All outputs are registered. Every output changes 1 cycle after the input that causes it.
- Reset (reset=0 at a clk edge): state MANUAL, sel_onehot=0, sel_idx=0, mode=0, wrap=0, dwell_cnt=0, change-snapshot valid flag=0.
- FSM states: MANUAL, AUTO, HOLD (HOLD exists only with CHG_JUMP_EN).
- MANUAL (sw[14]=0):
  - If sw[NUM_SRC-1:0] has exactly one bit set, sel_onehot = those bits and sel_idx = that bit's position.
  - If zero bits or two or more bits are set, sel_onehot = 0 and sel_idx holds its previous value.
  - sw[13:NUM_SRC] is ignored.
- MANUAL -> AUTO when sw[14]=1: idx = 0, dwell_cnt = 0, sel_onehot = 1<<0.
- AUTO:
  - dwell_cnt counts 0..DWELL_CYCLES-1 while pause=0.
  - When dwell_cnt == DWELL_CYCLES-1: idx <= (idx == NUM_SRC-1) ? 0 : idx+1, and dwell_cnt <= 0.
  - wrap = 1 for the cycle in which the new idx = 0 first appears.
- step=1 in AUTO advances idx immediately (same wrap rule and wrap pulse) and clears dwell_cnt. step is honoured even while pause=1.
- pause=1 freezes dwell_cnt and idx. Only step moves the selection.
- Simultaneous step and dwell expiry: a single advance, not a double one.
- AUTO or HOLD -> MANUAL whenever sw[14]=0 (highest priority after reset). The manual rule applies on the next cycle and dwell_cnt clears.
- sel_onehot is always either exactly 1<<sel_idx or 0. 0 occurs only in MANUAL.
- mode reflects the current state, with the same registered timing as sel_onehot.

Optional Feature:
- Macro: FND_SCHED_CHG_JUMP_EN.
- Defined:
  - A snapshot register captures src_data every cycle. The valid flag sets on the first cycle after reset, so no event fires from the reset snapshot.
  - In AUTO or HOLD, any byte that differs from its snapshot is a change event.
  - On an event, jump to the lowest changed index, enter HOLD, and clear dwell_cnt.
  - HOLD shows that source for DWELL_CYCLES (pause freezes the counter), then returns to AUTO with idx = held+1, using the wrap rule.
  - A new event during HOLD restarts HOLD on the new lowest changed index.
  - An event takes priority over step and over dwell expiry in the same cycle.
  - Events are ignored in MANUAL.
- Undefined: src_data is unused, no snapshot logic is built, the HOLD state is unreachable, and mode never equals 2.

Test Plan:
- DWELL_CYCLES=4, reset low 3 cycles then high, sw=0x0004 -> sel_onehot=0x004, sel_idx=2, mode=0 one cycle after reset release. Then sw=0x0006 -> sel_onehot=0x000, sel_idx stays 2.
- sw=0x4000 -> sel_idx sequence 0,0,0,0,1,1,1,1,2...; after idx 11 holds 4 cycles -> idx 0 with wrap=1 for exactly one cycle.
- AUTO at idx 5, pause=1 for 10 cycles -> idx stays 5. step pulse during pause -> idx 6 next cycle. Release pause -> idx 7 after 4 more cycles.
- AUTO with step asserted in the cycle dwell_cnt=3 at idx 3 -> idx 4 only, never 5. Then clear sw[14] mid-dwell with sw[3:0]=0x8 -> next cycle mode=0, sel_onehot=0x008.
- CHG_JUMP_EN, AUTO at idx 1, change src_data bytes 9 and 7 in the same cycle -> mode=2, sel_idx=7. After 4 cycles -> mode=1, sel_idx=8. No event fires in the first cycle after reset despite nonzero src_data.
- Apply reset=0 mid-HOLD at idx 7 -> next cycle mode=0, sel_onehot=0, sel_idx=0, wrap=0.

Source files
------------

// File: rtl/fnd_src_scheduler_if.sv
// fnd_src_scheduler_if
// Groups the display-source scheduler's control inputs and select outputs.
//   sw         : board switches (sw[14] auto enable, sw[NUM_SRC-1:0] manual one-hot)
//   pause      : level, freezes auto rotation
//   step       : one-cycle pulse, advances auto rotation by one source
//   src_data   : flattened source bytes, source k at [8k+7:8k]
//   sel_onehot : one-hot select to the source mux (all-zero = blank)
//   sel_idx    : binary index of the selected source
//   mode       : 0 = MANUAL, 1 = AUTO, 2 = HOLD
//   wrap       : one-cycle pulse when rotation wraps to source 0
// The master modport is the side that drives switches/buttons; the slave
// modport is the scheduler itself.
interface fnd_src_scheduler_if #(
  parameter int NUM_SRC = 12
) ();
  logic [14:0]          sw;
  logic                 pause;
  logic                 step;
  logic [NUM_SRC*8-1:0] src_data;
  logic [NUM_SRC-1:0]   sel_onehot;
  logic [3:0]           sel_idx;
  logic [1:0]           mode;
  logic                 wrap;

  modport master (
    output sw, pause, step, src_data,
    input  sel_onehot, sel_idx, mode, wrap
  );

  modport slave (
    input  sw, pause, step, src_data,
    output sel_onehot, sel_idx, mode, wrap
  );
endinterface

// File: rtl/fnd_src_scheduler.sv
// fnd_src_scheduler
// Produces the one-hot select for the 7-segment source mux. Selection is
// either manual (board switches) or an automatic round-robin that dwells
// DWELL_CYCLES clocks on each source, with pause and single-step controls.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-low reset
//   bus   : fnd_src_scheduler_if.slave (sw, pause, step, src_data in;
//           sel_onehot, sel_idx, mode, wrap out)
// All outputs are registered.
// Optional feature macro: FND_SCHED_CHG_JUMP_EN
//   When defined, a change in any source byte while in AUTO/HOLD jumps to the
//   lowest changed source and holds it for one dwell period (HOLD state).
//   When undefined, src_data is ignored and HOLD is never entered.
module fnd_src_scheduler #(
  parameter int NUM_SRC      = 12,
  parameter int DWELL_CYCLES = 100_000_000
) (
  input logic                clk,
  input logic                reset,
  fnd_src_scheduler_if.slave bus
);

  localparam int IDX_W = 4;
  localparam int CNT_W = (DWELL_CYCLES > 2) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SRC - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {
    MANUAL = 2'd0,
    AUTO   = 2'd1,
    HOLD   = 2'd2
  } state_e;

  state_e             state_d, state_q;
  logic [IDX_W-1:0]   idx_d, idx_q;
  logic [NUM_SRC-1:0] onehot_d, onehot_q;
  logic               wrap_d, wrap_q;
  logic [CNT_W-1:0]   dwell_d, dwell_q;

  logic [NUM_SRC-1:0] man_sel;
  logic               man_valid;
  logic [IDX_W-1:0]   man_pos;
  logic [IDX_W-1:0]   adv_idx;
  logic               adv_wrap;
  logic               chg_event;
  logic [IDX_W-1:0]   chg_idx;

  // Manual decode: position of the single set switch (only used when valid).
  assign man_sel   = bus.sw[NUM_SRC-1:0];
  assign man_valid = $onehot(man_sel);

  always_comb begin
    man_pos = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (man_sel[k]) man_pos = IDX_W'(k);
    end
  end

  assign adv_wrap = (idx_q == LAST_IDX);
  assign adv_idx  = adv_wrap ? '0 : idx_q + IDX_W'(1);

`ifdef FND_SCHED_CHG_JUMP_EN
  logic [NUM_SRC*8-1:0] snap_d, snap_q;
  logic                 snap_vld_d, snap_vld_q;
  logic                 chg_any;
  logic                 unused_sw;

  // Downward scan so the lowest changed source wins.
  always_comb begin
    snap_d     = bus.src_data;
    snap_vld_d = 1'b1;
    chg_any    = 1'b0;
    chg_idx    = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (bus.src_data[8*k +: 8] != snap_q[8*k +: 8]) begin
        chg_any = 1'b1;
        chg_idx = IDX_W'(k);
      end
    end
  end

  // The snapshot itself needs no reset; the valid flag masks the first compare.
  always_ff @(posedge clk) begin
    snap_q <= snap_d;
    if (!reset) snap_vld_q <= 1'b0;
    else        snap_vld_q <= snap_vld_d;
  end

  assign chg_event = snap_vld_q && chg_any;
  assign unused_sw = ^bus.sw[13:NUM_SRC];
`else
  logic unused_in;

  assign chg_event = 1'b0;
  assign chg_idx   = '0;
  assign unused_in = ^{bus.src_data, bus.sw[13:NUM_SRC]};
`endif

  // Next-state logic. Priority: sw[14]=0 (manual), entry into AUTO,
  // change event, step, then dwell counting (frozen by pause).
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    onehot_d = onehot_q;
    wrap_d   = 1'b0;
    dwell_d  = dwell_q;

    if (!bus.sw[14]) begin
      state_d = MANUAL;
      dwell_d = '0;
      if (man_valid) begin
        idx_d    = man_pos;
        onehot_d = man_sel;
      end else begin
        onehot_d = '0;
      end
    end else if (state_q == MANUAL) begin
      state_d = AUTO;
      idx_d   = '0;
      dwell_d = '0;
    end else if (chg_event) begin
      state_d = HOLD;
      idx_d   = chg_idx;
      dwell_d = '0;
    end else if (state_q == AUTO && bus.step) begin
      idx_d   = adv_idx;
      wrap_d  = adv_wrap;
      dwell_d = '0;
    end else if (!bus.pause) begin
      if (dwell_q == LAST_CNT) begin
        state_d = AUTO;
        idx_d   = adv_idx;
        wrap_d  = adv_wrap;
        dwell_d = '0;
      end else begin
        dwell_d = dwell_q + CNT_W'(1);
      end
    end

    // Outside MANUAL the select is always the decoded index.
    if (state_d != MANUAL) begin
      onehot_d = {{(NUM_SRC-1){1'b0}}, 1'b1} << idx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= MANUAL;
      idx_q    <= '0;
      onehot_q <= '0;
      wrap_q   <= 1'b0;
      dwell_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      onehot_q <= onehot_d;
      wrap_q   <= wrap_d;
      dwell_q  <= dwell_d;
    end
  end

  assign bus.sel_onehot = onehot_q;
  assign bus.sel_idx    = idx_q;
  assign bus.mode       = state_q;
  assign bus.wrap       = wrap_q;

endmodule
